// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: decode-stage RAW hazard unit for the 5-stage MIPS pipeline.
// Latency: stall is combinational from ID inputs and shadow state; fwd_a/fwd_b are
// registered and valid while the consumer sits in EX. Backpressure: stall holds PC/IF-ID
// and inserts a bubble into ID/EX; flush always overrides stall.
// Ports: clk, rst_n (async active-low); ir_id/id_valid/re1/re2/we_id/wr_id/ld_id/flush
// describe the ID instruction; stall, fwd_a, fwd_b and stall_cnt (saturating) are outputs.
// Build option: define HAZ_FORWARD_EN to compile in forwarding; stalls then occur only on
// load-use. Without it, every RAW hazard against EX or MEM stalls and the selects are 0.
module hazard_scoreboard #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      ir_id,
  input  logic             id_valid,
  input  logic             re1,
  input  logic             re2,
  input  logic             we_id,
  input  logic [4:0]       wr_id,
  input  logic             ld_id,
  input  logic             flush,
  output logic             stall,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_cnt
);

  // Shadow pipeline of in-flight destinations. The MEM-stage load flag is not kept:
  // load data is available on the MEM/WB path, so a load in MEM is never a stall cause.
  logic             ex_v_q, ex_v_d;
  logic [4:0]       ex_rd_q, ex_rd_d;
  logic             ex_ld_q, ex_ld_d;
  logic             mem_v_q;
  logic [4:0]       mem_rd_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [4:0] rs, rt;
  logic       ex_live, mem_live;
  logic       hit_ex_a, hit_ex_b, hit_mem_a, hit_mem_b;
  logic       hazard;
  logic       load_ex;
  logic       unused_ir;

  assign rs = ir_id[25:21];
  assign rt = ir_id[20:16];
  // Only the register fields are decoded here.
  assign unused_ir = ^{ir_id[31:26], ir_id[15:0]};

  // $0 is hardwired, so a producer of $0 never creates a dependence.
  assign ex_live  = ex_v_q  && (ex_rd_q  != 5'd0);
  assign mem_live = mem_v_q && (mem_rd_q != 5'd0);

  assign hit_ex_a  = id_valid && re1 && ex_live  && (rs == ex_rd_q);
  assign hit_ex_b  = id_valid && re2 && ex_live  && (rt == ex_rd_q);
  assign hit_mem_a = id_valid && re1 && mem_live && (rs == mem_rd_q);
  assign hit_mem_b = id_valid && re2 && mem_live && (rt == mem_rd_q);

  assign stall   = hazard && !flush;
  assign load_ex = !stall && !flush;

  always_comb begin
    ex_v_d  = 1'b0;
    ex_rd_d = 5'd0;
    ex_ld_d = 1'b0;
    if (load_ex) begin
      ex_v_d  = id_valid && we_id;
      ex_rd_d = wr_id;
      ex_ld_d = ld_id;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (stall && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_v_q   <= 1'b0;
      ex_rd_q  <= 5'd0;
      ex_ld_q  <= 1'b0;
      mem_v_q  <= 1'b0;
      mem_rd_q <= 5'd0;
      cnt_q    <= '0;
    end else begin
      mem_v_q  <= ex_v_q;
      mem_rd_q <= ex_rd_q;
      ex_v_q   <= ex_v_d;
      ex_rd_q  <= ex_rd_d;
      ex_ld_q  <= ex_ld_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stall_cnt = cnt_q;

`ifdef HAZ_FORWARD_EN
  logic [1:0] sel_a, sel_b;
  logic [1:0] fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;

  // Only a load still in EX has no result to forward yet.
  assign hazard = ex_ld_q && (hit_ex_a || hit_ex_b);

  // Nearest producer wins: EX/MEM result over MEM/WB result.
  always_comb begin
    sel_a = 2'd0;
    sel_b = 2'd0;
    if (hit_ex_a)       sel_a = 2'd1;
    else if (hit_mem_a) sel_a = 2'd2;
    if (hit_ex_b)       sel_b = 2'd1;
    else if (hit_mem_b) sel_b = 2'd2;
  end

  always_comb begin
    fwd_a_d = 2'd0;
    fwd_b_d = 2'd0;
    if (load_ex && id_valid) begin
      fwd_a_d = sel_a;
      fwd_b_d = sel_b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_a_q <= 2'd0;
      fwd_b_q <= 2'd0;
    end else begin
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
    end
  end

  assign fwd_a = fwd_a_q;
  assign fwd_b = fwd_b_q;
`else
  logic unused_ld;

  // No bypass network: hold the consumer until the producer reaches write-through WB.
  assign hazard    = hit_ex_a || hit_ex_b || hit_mem_a || hit_mem_b;
  assign fwd_a     = 2'd0;
  assign fwd_b     = 2'd0;
  assign unused_ld = ex_ld_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard; expectations follow the build selected by
// HAZ_FORWARD_EN. A second instance with a 4-bit counter exercises saturation.
module tb_hazard_scoreboard;

  logic        clk;
  logic        rst_n;
  logic [31:0] ir_id;
  logic        id_valid, re1, re2, we_id, ld_id, flush;
  logic [4:0]  wr_id;
  logic        stall, stall_s;
  logic [1:0]  fwd_a, fwd_b, fwd_a_s, fwd_b_s;
  logic [15:0] stall_cnt;
  logic [3:0]  stall_cnt_s;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  hazard_scoreboard #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .ir_id(ir_id), .id_valid(id_valid), .re1(re1), .re2(re2),
    .we_id(we_id), .wr_id(wr_id), .ld_id(ld_id), .flush(flush),
    .stall(stall), .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt)
  );

  hazard_scoreboard #(.CNT_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .ir_id(ir_id), .id_valid(id_valid), .re1(re1), .re2(re2),
    .we_id(we_id), .wr_id(wr_id), .ld_id(ld_id), .flush(flush),
    .stall(stall_s), .fwd_a(fwd_a_s), .fwd_b(fwd_b_s), .stall_cnt(stall_cnt_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_id(input logic v, input logic r1, input logic r2, input logic we,
                        input logic [4:0] wr, input logic ld, input logic fl,
                        input logic [4:0] rs, input logic [4:0] rt);
    id_valid = v;
    re1      = r1;
    re2      = r2;
    we_id    = we;
    wr_id    = wr;
    ld_id    = ld;
    flush    = fl;
    ir_id    = {6'h00, rs, rt, 16'h0004};
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic nop();
    set_id(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0);
  endtask

  task automatic drain();
    nop();
    tick();
    tick();
  endtask

  initial begin
    // Reset with a would-be hazard on the inputs: nothing may be live.
    rst_n = 1'b0;
    set_id(1'b1, 1'b1, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 5'd3, 5'd3);
    chk("reset_stall", {31'd0, stall}, 32'd0);
    chk("reset_fwd", {28'd0, fwd_a, fwd_b}, 32'd0);
    chk("reset_cnt", {16'd0, stall_cnt}, 32'd0);
    chk("reset_cnt_sat", {28'd0, stall_cnt_s}, 32'd0);
    rst_n = 1'b1;
    nop();
    tick();

    // add $3,$1,$2 ; sub $4,$3,$5
    set_id(1'b1, 1'b1, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0, 5'd1, 5'd2);
    chk("add_no_stall", {31'd0, stall}, 32'd0);
    tick();
    set_id(1'b1, 1'b1, 1'b1, 1'b1, 5'd4, 1'b0, 1'b0, 5'd3, 5'd5);
`ifdef HAZ_FORWARD_EN
    chk("raw1_stall", {31'd0, stall}, 32'd0);
    tick();
    chk("raw1_fwd_a", {30'd0, fwd_a}, 32'd1);
    chk("raw1_fwd_b", {30'd0, fwd_b}, 32'd0);
`else
    chk("raw1_stall_c1", {31'd0, stall}, 32'd1);
    tick();
    chk("raw1_stall_c2", {31'd0, stall}, 32'd1);
    tick();
    chk("raw1_stall_c3", {31'd0, stall}, 32'd0);
    tick();
    chk("raw1_fwd_a", {30'd0, fwd_a}, 32'd0);
    exp_cnt += 2;
`endif
    chk("raw1_cnt", {16'd0, stall_cnt}, exp_cnt);
    drain();

    // lw $3,0($1) ; sw $3,4($2)
    set_id(1'b1, 1'b1, 1'b0, 1'b1, 5'd3, 1'b1, 1'b0, 5'd1, 5'd0);
    chk("lw_no_stall", {31'd0, stall}, 32'd0);
    tick();
    set_id(1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd2, 5'd3);
`ifdef HAZ_FORWARD_EN
    chk("lu_stall_c1", {31'd0, stall}, 32'd1);
    tick();
    chk("lu_cnt", {16'd0, stall_cnt}, 32'd1);
    chk("lu_stall_c2", {31'd0, stall}, 32'd0);
    chk("lu_bubble_fwd_b", {30'd0, fwd_b}, 32'd0);
    tick();
    chk("lu_fwd_b", {30'd0, fwd_b}, 32'd2);
    chk("lu_fwd_a", {30'd0, fwd_a}, 32'd0);
    exp_cnt += 1;
`else
    chk("lu_stall_c1", {31'd0, stall}, 32'd1);
    tick();
    chk("lu_stall_c2", {31'd0, stall}, 32'd1);
    tick();
    chk("lu_stall_c3", {31'd0, stall}, 32'd0);
    tick();
    chk("lu_fwd_b", {30'd0, fwd_b}, 32'd0);
    exp_cnt += 2;
`endif
    chk("lu_cnt_total", {16'd0, stall_cnt}, exp_cnt);
    drain();

    // Producer of $0, consumer of $0 on both sources.
    set_id(1'b1, 1'b1, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 5'd1, 5'd2);
    tick();
    set_id(1'b1, 1'b1, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 5'd0, 5'd0);
    chk("r0_stall", {31'd0, stall}, 32'd0);
    tick();
    chk("r0_fwd", {28'd0, fwd_a, fwd_b}, 32'd0);
    drain();

    // Load-use with simultaneous flush; the flushed consumer (writes $4) must not enter EX.
    set_id(1'b1, 1'b1, 1'b0, 1'b1, 5'd3, 1'b1, 1'b0, 5'd1, 5'd0);
    tick();
    set_id(1'b1, 1'b1, 1'b0, 1'b1, 5'd4, 1'b0, 1'b1, 5'd3, 5'd0);
    chk("flush_stall", {31'd0, stall}, 32'd0);
    tick();
    chk("flush_fwd", {28'd0, fwd_a, fwd_b}, 32'd0);
    set_id(1'b1, 1'b1, 1'b0, 1'b1, 5'd6, 1'b0, 1'b0, 5'd4, 5'd0);
    chk("flush_bubble_stall", {31'd0, stall}, 32'd0);
    tick();
    chk("flush_bubble_fwd_a", {30'd0, fwd_a}, 32'd0);
    chk("flush_cnt", {16'd0, stall_cnt}, exp_cnt);
    drain();

    // Two producers of $7 at distance 2 and 1, then a reader of $7.
    set_id(1'b1, 1'b1, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 5'd1, 5'd2);
    tick();
    set_id(1'b1, 1'b1, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 5'd2, 5'd1);
    tick();
    // Gated sources never stall: re1=0, then id_valid=0.
    set_id(1'b1, 1'b0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 5'd7, 5'd7);
    chk("re_off_stall", {31'd0, stall}, 32'd0);
    set_id(1'b0, 1'b1, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0, 5'd7, 5'd7);
    chk("invalid_stall", {31'd0, stall}, 32'd0);
    set_id(1'b1, 1'b1, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 5'd7, 5'd1);
`ifdef HAZ_FORWARD_EN
    chk("near_stall", {31'd0, stall}, 32'd0);
    tick();
    chk("near_fwd_a", {30'd0, fwd_a}, 32'd1);
`else
    chk("near_stall_c1", {31'd0, stall}, 32'd1);
    tick();
    chk("near_stall_c2", {31'd0, stall}, 32'd1);
    tick();
    chk("near_stall_c3", {31'd0, stall}, 32'd0);
    tick();
    chk("near_fwd_a", {30'd0, fwd_a}, 32'd0);
    exp_cnt += 2;
`endif
    chk("near_cnt", {16'd0, stall_cnt}, exp_cnt);
    drain();

    // Saturation: self-dependent instruction ($3 <- f($3)) held in ID from an empty
    // shadow pipe; 24 stall cycles total, which pins the 4-bit counter at 0xF.
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    set_id(1'b1, 1'b1, 1'b0, 1'b1, 5'd3, 1'b1, 1'b0, 5'd3, 5'd0);
`ifdef HAZ_FORWARD_EN
    for (int k = 0; k < 49; k++) tick();
`else
    for (int k = 0; k < 37; k++) tick();
`endif
    chk("sat_stall_live", {31'd0, stall}, 32'd1);
    chk("sat_cnt16", {16'd0, stall_cnt}, 32'd24);
    chk("sat_cnt4", {28'd0, stall_cnt_s}, 32'd15);
    tick();
    chk("sat_cnt4_hold", {28'd0, stall_cnt_s}, 32'd15);
    chk("sat_cnt16_step", {16'd0, stall_cnt}, 32'd25);
    // Mid-stall reset clears everything without waiting for a clock edge.
    set_id(1'b1, 1'b1, 1'b0, 1'b1, 5'd3, 1'b1, 1'b0, 5'd3, 5'd0);
`ifdef HAZ_FORWARD_EN
    tick();
`endif
    chk("pre_rst_stall", {31'd0, stall}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_cnt16", {16'd0, stall_cnt}, 32'd0);
    chk("rst_cnt4", {28'd0, stall_cnt_s}, 32'd0);
    chk("rst_fwd", {28'd0, fwd_a, fwd_b}, 32'd0);
    rst_n = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
